// File: rtl/viterbi_block_decoder_if.sv
// Handshake bundle for viterbi_block_decoder.
// Ports (master = surrounding system, slave = decoder):
//   in_valid/in_ready/code_in    : codeword input handshake
//   out_valid/out_ready/msg_out  : decoded message output handshake
//   err_cnt                      : corrected bit count (VITERBI_ERR_CNT_EN only)
interface viterbi_block_decoder_if #(
    parameter int MSG_BITS = 14
);
    localparam int N       = MSG_BITS + 2;
    localparam int CW_BITS = 2 * N;

    logic                in_valid;
    logic                in_ready;
    logic [CW_BITS-1:0]  code_in;
    logic                out_valid;
    logic                out_ready;
    logic [MSG_BITS-1:0] msg_out;

`ifdef VITERBI_ERR_CNT_EN
    localparam int MW = $clog2(2 * N + 1);
    logic [MW-1:0] err_cnt;

    modport master (
        output in_valid, code_in, out_ready,
        input  in_ready, out_valid, msg_out, err_cnt
    );
    modport slave (
        input  in_valid, code_in, out_ready,
        output in_ready, out_valid, msg_out, err_cnt
    );
`else
    modport master (
        output in_valid, code_in, out_ready,
        input  in_ready, out_valid, msg_out
    );
    modport slave (
        input  in_valid, code_in, out_ready,
        output in_ready, out_valid, msg_out
    );
`endif
endinterface

// File: rtl/viterbi_block_decoder.sv
// Sequential hard-decision Viterbi decoder, rate 1/2, K=3, zero-tail.
// One ACS trellis step per cycle, then one traceback step per cycle.
// Ports: clk, rst (sync, active-high), bus (viterbi_block_decoder_if.slave).
// Optional macro VITERBI_ERR_CNT_EN adds the registered err_cnt output.
module viterbi_block_decoder #(
    parameter int         MSG_BITS = 14,
    parameter logic [2:0] G0       = 3'b111,
    parameter logic [2:0] G1       = 3'b101
) (
    input  logic                    clk,
    input  logic                    rst,
    viterbi_block_decoder_if.slave  bus
);
    localparam int N       = MSG_BITS + 2;
    localparam int CW_BITS = 2 * N;
    localparam int MW      = $clog2(2 * N + 1);
    localparam int CNT_W   = $clog2(N + 1);
    localparam int TW      = $clog2(N);

    typedef enum logic [1:0] {IDLE, ACS, TRACE, DONE} state_t;

    state_t              state;
    state_t              state_nx;
    logic [CW_BITS-1:0]  code_sr;
    logic [MW-1:0]       metric    [4];
    logic [MW-1:0]       metric_nx [4];
    logic [3:0]          surv      [N];
    logic [3:0]          surv_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    t_idx;
    logic [1:0]          tb_state;
    logic [MSG_BITS-1:0] msg_sr;
    logic [MSG_BITS-1:0] msg_q;
    logic [1:0]          rx;

    function automatic logic [1:0] branch_metric(
        input logic [1:0] r,
        input logic [2:0] path
    );
        logic [1:0] d;
        d = r ^ {^(G0 & path), ^(G1 & path)};
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    function automatic logic [MW-1:0] sat_add(
        input logic [MW-1:0] a,
        input logic [1:0]    b
    );
        logic [MW:0] s;
        s = {1'b0, a} + {{(MW-1){1'b0}}, b};
        return s[MW] ? '1 : s[MW-1:0];
    endfunction

    // Received pair for the current step sits at the top of the shifter.
    assign rx = code_sr[CW_BITS-1 -: 2];

    // Next state n = {u,b}; predecessors {b,0} and {b,1}.
    // Ties keep predecessor {b,0}.
    for (genvar n = 0; n < 4; n++) begin : g_acs
        localparam logic [1:0] NS = 2'(n);
        localparam logic [1:0] P0 = {NS[0], 1'b0};
        localparam logic [1:0] P1 = {NS[0], 1'b1};
        logic [MW-1:0] c0;
        logic [MW-1:0] c1;
        assign c0 = sat_add(metric[P0], branch_metric(rx, {NS[1], P0}));
        assign c1 = sat_add(metric[P1], branch_metric(rx, {NS[1], P1}));
        assign surv_nx[n]   = (c1 < c0);
        assign metric_nx[n] = (c1 < c0) ? c1 : c0;
    end

    // Traceback counts cnt from N down to 1 (step t = cnt-1);
    // cnt == 0 is the cycle that registers the result.
    assign t_idx = cnt - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = !rst;
                if (bus.in_valid) state_nx = ACS;
            end
            ACS: begin
                if (cnt == CNT_W'(N - 1)) state_nx = TRACE;
            end
            TRACE: begin
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Survivor memory needs no reset: each entry is written before use.
    always_ff @(posedge clk) begin
        if (state == ACS) surv[cnt[TW-1:0]] <= surv_nx;
    end

`ifdef VITERBI_ERR_CNT_EN
    logic [MW-1:0] err_q;
    assign bus.err_cnt = err_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= '0;
        else if (state == TRACE && cnt == '0)
            err_q <= metric[0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            code_sr  <= '0;
            cnt      <= '0;
            tb_state <= '0;
            msg_sr   <= '0;
            msg_q    <= '0;
            for (int i = 0; i < 4; i++) metric[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        code_sr   <= bus.code_in;
                        cnt       <= '0;
                        metric[0] <= '0;
                        metric[1] <= '1;
                        metric[2] <= '1;
                        metric[3] <= '1;
                    end
                end
                ACS: begin
                    code_sr <= code_sr << 2;
                    for (int i = 0; i < 4; i++) metric[i] <= metric_nx[i];
                    if (cnt == CNT_W'(N - 1)) begin
                        cnt      <= CNT_W'(N);
                        tb_state <= 2'b00;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TRACE: begin
                    if (cnt != '0) begin
                        // Bits arrive last-first; tail bits fall off the bottom.
                        msg_sr   <= {tb_state[1], msg_sr[MSG_BITS-1:1]};
                        tb_state <= {tb_state[0],
                                     surv[t_idx[TW-1:0]][tb_state]};
                        cnt      <= cnt - 1'b1;
                    end else begin
                        msg_q <= msg_sr;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    assign bus.msg_out = msg_q;

endmodule

// File: tb/tb_viterbi_block_decoder.sv
// Self-checking bench for viterbi_block_decoder (default parameters).
// Scoreboard of expected messages, directed steps plus encoded randoms.
module tb_viterbi_block_decoder;
    localparam int MSG_BITS = 14;
    localparam int N        = MSG_BITS + 2;
    localparam int CW       = 2 * N;
    localparam int MW       = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    viterbi_block_decoder_if #(.MSG_BITS(MSG_BITS)) bus();

    viterbi_block_decoder #(
        .MSG_BITS(MSG_BITS),
        .G0(3'b111),
        .G1(3'b101)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [MSG_BITS-1:0] msg;
        logic [MW-1:0]       err;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: u[t] = msg[13-t], two zero tail bits.
    function automatic logic [CW-1:0] encode(input logic [MSG_BITS-1:0] m);
        logic [1:0]    s;
        logic          u;
        logic [CW-1:0] c;
        s = 2'b00;
        c = '0;
        for (int t = 0; t < N; t++) begin
            u = (t < MSG_BITS) ? m[MSG_BITS-1-t] : 1'b0;
            c[CW-1-2*t] = ^(3'b111 & {u, s});
            c[CW-2-2*t] = ^(3'b101 & {u, s});
            s = {u, s[1]};
        end
        return c;
    endfunction

    // Called at #1 after an edge; returns at #1 after the accept edge.
    task automatic send(input logic [CW-1:0] code,
                        input logic [MSG_BITS-1:0] msg,
                        input logic [MW-1:0] err, input bit push);
        exp_t e;
        int   w;
        w = 0;
        while (!bus.in_ready && w < 60) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        bus.code_in  = code;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.code_in  = '0;
        if (push) begin
            e.msg = msg;
            e.err = err;
            sb.push_back(e);
        end
    endtask

    // Waits for out_valid, compares, optionally holds off out_ready.
    task automatic collect(input string tag, input bit chk_lat,
                           input int hold);
        exp_t e;
        int   lat;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) chk({tag, "_valid_timeout"}, 0, 1);
        if (chk_lat) chk({tag, "_latency"}, lat, 33);
        e = sb.pop_front();
        chk({tag, "_msg"}, bus.msg_out, e.msg);
`ifdef VITERBI_ERR_CNT_EN
        chk({tag, "_err"}, bus.err_cnt, e.err);
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, bus.out_valid, 1);
            chk({tag, "_hold_msg"}, bus.msg_out, e.msg);
            chk({tag, "_hold_ready"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_release_ready"}, bus.in_ready, 1);
        chk({tag, "_release_valid"}, bus.out_valid, 0);
    endtask

    initial begin
        logic [MSG_BITS-1:0] m;
        logic [CW-1:0]       c;
        int                  seen;
        bus.in_valid  = 1'b0;
        bus.code_in   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_msg", bus.msg_out, 0);
`ifdef VITERBI_ERR_CNT_EN
        chk("rst_err", bus.err_cnt, 0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        send(32'h0000_0000, 14'h0000, 0, 1);
        collect("zero", 1, 0);
        send(32'hEC00_0000, 14'h2000, 0, 1);
        collect("ec00", 1, 0);
        send(32'h6C00_0000, 14'h2000, 1, 1);
        collect("err1", 1, 0);
        send(32'h6C00_0001, 14'h2000, 2, 1);
        collect("err2", 1, 0);

        send(encode(14'h2A5C), 14'h2A5C, 0, 1);
        collect("bp", 0, 10);

        for (int k = 0; k < 3; k++) begin
            m = 14'($urandom);
            send(encode(m), m, 0, 1);
            collect("rnd_clean", 1, 0);
        end
        for (int k = 0; k < 3; k++) begin
            m = 14'($urandom);
            c = encode(m);
            c[$urandom_range(0, CW - 1)] ^= 1'b1;
            send(c, m, 1, 1);
            collect("rnd_1err", 1, 0);
        end

        send(32'h6C00_0001, 14'h2000, 2, 0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_in_ready_rst", bus.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_msg", bus.msg_out, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        send(32'hEC00_0000, 14'h2000, 0, 1);
        collect("after_abort", 1, 0);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
